subkey_sequencer: RTL

SUBKEY_SEQUENCER -- requirements
Module: subkey_sequencer

---
 rtl/subkey_sequencer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/subkey_sequencer.sv
// ---------------------------------------------------------------------------
// subkey_sequencer
//
// Control sequencer for one Threefish-1024 key-schedule subkey. A request
// carries a subkey number s. The sequencer first runs three PREP cycles that
// load the selector's word-13/14/15 subkey registers with their addends
// (tweak word s mod 3, tweak word (s+1) mod 3, and s itself). It then streams
// words 0..WORDS-1 to a downstream consumer using a valid/ready handshake,
// and finally pulses done_o for one cycle.
//
// Ports
//   clk_i                 single clock, rising edge
//   rst_i                 asynchronous active-low reset
//   start_i               request strobe, honoured only while idle
//   subkey_index_i [4:0]  subkey number s, captured with an accepted start
//   word_ready_i          consumer accepts the current streamed word
//   subkey_select_o [4:0] captured s, held until the next accepted start
//   subkey_word_select_o [3:0]  word index presented to the selector
//   write_o               write strobe for the word-13/14/15 registers
//   add_src_o [1:0]       addend source: 0 none, 1 tweak word, 2 s
//   tweak_select_o [1:0]  tweak word index (valid when add_src_o = 1)
//   word_valid_o          selector output holds word word_index_o
//   word_index_o [3:0]    index of the streamed word
//   last_o                streamed word is the final one
//   busy_o                request in progress
//   done_o                one-cycle pulse after the final word is accepted
//   err_o                 one-cycle pulse after a start with s > SUBKEY_MAX
// ---------------------------------------------------------------------------
module subkey_sequencer #(
  parameter int SUBKEY_MAX = 20,
  parameter int WORDS      = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [4:0] subkey_index_i,
  input  logic       word_ready_i,
  output logic [4:0] subkey_select_o,
  output logic [3:0] subkey_word_select_o,
  output logic       write_o,
  output logic [1:0] add_src_o,
  output logic [1:0] tweak_select_o,
  output logic       word_valid_o,
  output logic [3:0] word_index_o,
  output logic       last_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PREP   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [4:0] S_MAX  = 5'(SUBKEY_MAX);
  localparam logic [3:0] W_LAST = 4'(WORDS - 1);

  localparam logic [1:0] ADD_NONE  = 2'd0;
  localparam logic [1:0] ADD_TWEAK = 2'd1;
  localparam logic [1:0] ADD_S     = 2'd2;

  state_t     state_q, state_d;
  logic [1:0] p_q, p_d;
  logic [3:0] w_q, w_d;
  logic [4:0] s_q, s_d;
  logic [1:0] tw0_q, tw0_d;
  logic [1:0] tw1_q, tw1_d;
  logic       err_q, err_d;

  // The mod-3 reduction is done on the request input at capture time and
  // stored, so the PREP outputs come straight from flops.
  logic [4:0] idx_mod3;
  logic [1:0] idx_tw0;
  logic [1:0] idx_tw1;

  assign idx_mod3 = subkey_index_i % 5'd3;
  assign idx_tw0  = idx_mod3[1:0];
  assign idx_tw1  = (idx_tw0 == 2'd2) ? 2'd0 : 2'(idx_tw0 + 2'd1);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      p_q     <= '0;
      w_q     <= '0;
      s_q     <= '0;
      tw0_q   <= '0;
      tw1_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      w_q     <= w_d;
      s_q     <= s_d;
      tw0_q   <= tw0_d;
      tw1_q   <= tw1_d;
      err_q   <= err_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and output decode
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    w_d     = w_q;
    s_d     = s_q;
    tw0_d   = tw0_q;
    tw1_d   = tw1_q;
    err_d   = 1'b0;

    subkey_word_select_o = '0;
    write_o              = 1'b0;
    add_src_o            = ADD_NONE;
    tweak_select_o       = '0;
    word_valid_o         = 1'b0;
    word_index_o         = '0;
    last_o               = 1'b0;
    busy_o               = 1'b0;
    done_o               = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (subkey_index_i > S_MAX) begin
            err_d = 1'b1;
          end else begin
            s_d     = subkey_index_i;
            tw0_d   = idx_tw0;
            tw1_d   = idx_tw1;
            p_d     = '0;
            state_d = PREP;
          end
        end
      end

      PREP: begin
        busy_o               = 1'b1;
        write_o              = 1'b1;
        subkey_word_select_o = 4'd13 + {2'b00, p_q};
        case (p_q)
          2'd0: begin
            add_src_o      = ADD_TWEAK;
            tweak_select_o = tw0_q;
          end
          2'd1: begin
            add_src_o      = ADD_TWEAK;
            tweak_select_o = tw1_q;
          end
          default: begin
            add_src_o      = ADD_S;
            tweak_select_o = '0;
          end
        endcase
        if (p_q == 2'd2) begin
          p_d     = '0;
          w_d     = '0;
          state_d = STREAM;
        end else begin
          p_d = 2'(p_q + 2'd1);
        end
      end

      STREAM: begin
        busy_o               = 1'b1;
        word_valid_o         = 1'b1;
        subkey_word_select_o = w_q;
        word_index_o         = w_q;
        last_o               = (w_q == W_LAST);
        if (word_ready_i) begin
          if (w_q == W_LAST) begin
            state_d = DONE;
          end else begin
            w_d = 4'(w_q + 4'd1);
          end
        end
      end

      DONE: begin
        busy_o  = 1'b1;
        done_o  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign subkey_select_o = s_q;
  assign err_o           = err_q;

endmodule
